// File: rtl/rgb_panel_pkg.sv
// Shared types and constants for the RGB LED matrix panel driver.
package rgb_panel_pkg;

    localparam int DEFAULT_NUM_ROWS       = 16;
    localparam int DEFAULT_DISPLAY_CYCLES = 1000;
    localparam int DEFAULT_BLANK_CYCLES   = 2;
    localparam int DEFAULT_LATCH_CYCLES   = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        ADVANCE = 3'd4
    } scan_state_t;

    // Width of a row index; never narrower than one bit.
    function automatic int row_width(input int rows);
        return (rows < 2) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/row_scan_controller_phase_timer.sv
// Loadable down-counter that times the fixed-length BLANK and LATCH phases.
// Loading N-1 on phase entry makes done assert in the N-th cycle of the phase.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/row_scan_controller.sv
// Row-scan sequencer: lets the column filler shift the next row while the
// previously latched row is lit, then blanks, latches and advances the address.
module row_scan_controller
    import rgb_panel_pkg::*;
#(
    parameter  int NUM_ROWS       = DEFAULT_NUM_ROWS,
    parameter  int DISPLAY_CYCLES = DEFAULT_DISPLAY_CYCLES,
    parameter  int BLANK_CYCLES   = DEFAULT_BLANK_CYCLES,
    parameter  int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
    localparam int ROW_W          = row_width(NUM_ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             filled,
    output logic             fill_enable,
    output logic [ROW_W-1:0] fill_row,
    output logic [ROW_W-1:0] row_addr,
    output logic             latch,
    output logic             oe_n,
    output logic             frame_done
);

    localparam int DW     = $clog2(DISPLAY_CYCLES + 1);
    localparam int PH_MAX = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int TW     = $clog2(PH_MAX + 1);

    scan_state_t   state;
    scan_state_t   state_next;
    logic [DW-1:0] dwell;
    logic          shown_valid;
    logic          shown_valid_next;
    logic          filled_seen;
    logic          fill_hit;
    logic          lit_enough;
    logic          row_wrap;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_done;

    // dwell counts FILL cycles already completed, so the current FILL cycle
    // is the DISPLAY_CYCLES-th lit cycle when dwell reaches DISPLAY_CYCLES-1.
    assign fill_hit         = filled_seen | filled;
    assign lit_enough       = (dwell >= DW'(DISPLAY_CYCLES - 1));
    assign row_wrap         = (fill_row == ROW_W'(NUM_ROWS - 1));
    assign shown_valid_next = shown_valid | (state == ADVANCE);

    // Next-state decision for the scan sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = FILL;
            FILL:    if (fill_hit && (lit_enough || !shown_valid)) state_next = BLANK;
            BLANK:   if (timer_done) state_next = LATCH;
            LATCH:   if (timer_done) state_next = ADVANCE;
            ADVANCE: state_next = run ? FILL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arm the phase timer on entry to BLANK or LATCH.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state_next == BLANK && state != BLANK) begin
            timer_load  = 1'b1;
            timer_value = TW'(BLANK_CYCLES - 1);
        end else if (state_next == LATCH && state != LATCH) begin
            timer_load  = 1'b1;
            timer_value = TW'(LATCH_CYCLES - 1);
        end
    end

    phase_timer #(
        .W(TW)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // State, bookkeeping and registered panel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fill_enable <= 1'b0;
            fill_row    <= '0;
            row_addr    <= '0;
            latch       <= 1'b0;
            oe_n        <= 1'b1;
            frame_done  <= 1'b0;
            dwell       <= '0;
            shown_valid <= 1'b0;
            filled_seen <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every term below sees pre-edge values.
            state <= state_next;

            // Outputs are decoded from state_next so they change on the same
            // edge as the state they belong to, yet stay glitch-free registers.
            fill_enable <= (state_next == FILL);
            latch       <= (state_next == LATCH);
            oe_n        <= !((state_next == FILL) && shown_valid_next);
            frame_done  <= 1'b0;

            if (state == FILL) begin
                if (dwell != DW'(DISPLAY_CYCLES)) dwell <= dwell + 1'b1;
                if (filled) filled_seen <= 1'b1;
            end

            if (state == ADVANCE) begin
                row_addr    <= fill_row;
                fill_row    <= row_wrap ? '0 : fill_row + 1'b1;
                frame_done  <= row_wrap;
                shown_valid <= 1'b1;
                dwell       <= '0;
                filled_seen <= 1'b0;
            end
        end
    end

endmodule
